// File: rtl/bundle_parser.sv
// Two-stage fetch-bundle parser: stage 1 registers a packed bundle of 19b/30b instructions,
// stage 2 walks it into up to ISSUE_W decoded slots, with valid/ready on both sides.
module bundle_parser #(
  parameter int unsigned BUNDLE_W    = 60,
  parameter int unsigned ISSUE_W     = 2,
  parameter bit          BRANCH_STOP = 1'b0
) (
  input  logic                             clock_i,
  input  logic                             reset_i,
  input  logic                             flush_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [BUNDLE_W-1:0]              bundle_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [ISSUE_W-1:0]               slot_valid_o,
  output logic [ISSUE_W-1:0]               format_o,
  output logic [ISSUE_W-1:0]               branch_o,
  output logic [7*ISSUE_W-1:0]             opcode_o,
  output logic [5*ISSUE_W-1:0]             reg_o,
  output logic [16*ISSUE_W-1:0]            operand_o,
  output logic [$clog2(ISSUE_W+1)-1:0]     count_o,
  output logic [$clog2(BUNDLE_W+1)-1:0]    used_o
);

  localparam int unsigned CntW  = $clog2(ISSUE_W + 1);
  localparam int unsigned UsedW = $clog2(BUNDLE_W + 1);
  localparam int unsigned PadW  = BUNDLE_W + 30;
  localparam int unsigned OffW  = $clog2(BUNDLE_W + 31);

  logic                  s1_valid_q;
  logic [BUNDLE_W-1:0]   s1_bundle_q;
  logic                  out_valid_q;
  logic [ISSUE_W-1:0]    sv_q, fmt_q, br_q;
  logic [7*ISSUE_W-1:0]  op_q;
  logic [5*ISSUE_W-1:0]  rg_q;
  logic [16*ISSUE_W-1:0] opd_q;
  logic [CntW-1:0]       cnt_q;
  logic [UsedW-1:0]      used_q;

  logic [ISSUE_W-1:0]    sv_d, fmt_d, br_d;
  logic [7*ISSUE_W-1:0]  op_d;
  logic [5*ISSUE_W-1:0]  rg_d;
  logic [16*ISSUE_W-1:0] opd_d;
  logic [CntW-1:0]       cnt_d;
  logic [UsedW-1:0]      used_d;

  logic                  s2_load;
  logic                  accept;

  logic [OffW-1:0]       walk_off;
  logic [OffW-1:0]       walk_len;
  logic                  walk_live;
  logic                  walk_fmt;
  logic                  walk_br;
  logic [PadW-1:0]       walk_win;

  assign s2_load    = s1_valid_q & (~out_valid_q | out_ready_i);
  assign in_ready_o = ~reset_i & ~flush_i & (~s1_valid_q | s2_load);
  assign accept     = in_valid_i & in_ready_o;

  // Slot walk: shift the zero-padded bundle so the current slot sits at the MSB,
  // which keeps every field extraction at a fixed bit position.
  always_comb begin
    sv_d      = '0;
    fmt_d     = '0;
    br_d      = '0;
    op_d      = '0;
    rg_d      = '0;
    opd_d     = '0;
    cnt_d     = '0;
    walk_off  = '0;
    walk_len  = '0;
    walk_live = 1'b1;
    walk_fmt  = 1'b0;
    walk_br   = 1'b0;
    walk_win  = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      walk_win = {s1_bundle_q, 30'b0} << walk_off;
      walk_fmt = walk_win[PadW-1];
      walk_br  = walk_win[PadW-2];
      walk_len = walk_fmt ? OffW'(30) : OffW'(19);
      if (walk_live && (walk_off < OffW'(BUNDLE_W)) &&
          ((walk_off + walk_len) <= OffW'(BUNDLE_W))) begin
        sv_d[k]            = 1'b1;
        fmt_d[k]           = walk_fmt;
        br_d[k]            = walk_br;
        op_d[7*k +: 7]     = walk_win[PadW-3 -: 7];
        rg_d[5*k +: 5]     = walk_win[PadW-10 -: 5];
        opd_d[16*k +: 16]  = walk_fmt ? walk_win[PadW-15 -: 16]
                                      : {11'b0, walk_win[PadW-15 -: 5]};
        walk_off           = walk_off + walk_len;
        cnt_d              = cnt_d + CntW'(1);
        if (BRANCH_STOP && walk_br) begin
          walk_live = 1'b0;
        end
      end else begin
        walk_live = 1'b0;
      end
    end
    used_d = UsedW'(walk_off);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      s1_valid_q  <= 1'b0;
      s1_bundle_q <= '0;
      out_valid_q <= 1'b0;
      sv_q        <= '0;
      fmt_q       <= '0;
      br_q        <= '0;
      op_q        <= '0;
      rg_q        <= '0;
      opd_q       <= '0;
      cnt_q       <= '0;
      used_q      <= '0;
    end else if (flush_i) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid_q  <= 1'b1;
        s1_bundle_q <= bundle_i;
      end else if (s2_load) begin
        s1_valid_q  <= 1'b0;
      end
      if (s2_load) begin
        out_valid_q <= 1'b1;
        sv_q        <= sv_d;
        fmt_q       <= fmt_d;
        br_q        <= br_d;
        op_q        <= op_d;
        rg_q        <= rg_d;
        opd_q       <= opd_d;
        cnt_q       <= cnt_d;
        used_q      <= used_d;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o  = out_valid_q;
  assign slot_valid_o = sv_q;
  assign format_o     = fmt_q;
  assign branch_o     = br_q;
  assign opcode_o     = op_q;
  assign reg_o        = rg_q;
  assign operand_o    = opd_q;
  assign count_o      = cnt_q;
  assign used_o       = used_q;

endmodule

// File: tb/tb_bundle_parser.sv
// Bench for bundle_parser: a default instance and an ISSUE_W=3 branch-stop instance share
// stimulus; a queue-based pipeline model and a bit-level slot parser supply expectations.
module tb_bundle_parser;

  localparam int BW = 60;

  logic clk = 1'b0;
  logic reset, flush, in_valid, out_ready;
  logic [BW-1:0] bundle;

  logic a_in_ready, a_ov;
  logic [1:0] a_sv, a_fmt, a_br, a_cnt;
  logic [13:0] a_op;
  logic [9:0] a_rg;
  logic [31:0] a_opd;
  logic [5:0] a_used;

  logic b_in_ready, b_ov;
  logic [2:0] b_sv, b_fmt, b_br;
  logic [1:0] b_cnt;
  logic [20:0] b_op;
  logic [14:0] b_rg;
  logic [47:0] b_opd;
  logic [5:0] b_used;

  bundle_parser dut_a (
    .clock_i(clk), .reset_i(reset), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(a_in_ready), .bundle_i(bundle), .out_valid_o(a_ov), .out_ready_i(out_ready),
    .slot_valid_o(a_sv), .format_o(a_fmt), .branch_o(a_br), .opcode_o(a_op), .reg_o(a_rg),
    .operand_o(a_opd), .count_o(a_cnt), .used_o(a_used)
  );

  bundle_parser #(.BUNDLE_W(60), .ISSUE_W(3), .BRANCH_STOP(1'b1)) dut_b (
    .clock_i(clk), .reset_i(reset), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(b_in_ready), .bundle_i(bundle), .out_valid_o(b_ov), .out_ready_i(out_ready),
    .slot_valid_o(b_sv), .format_o(b_fmt), .branch_o(b_br), .opcode_o(b_op), .reg_o(b_rg),
    .operand_o(b_opd), .count_o(b_cnt), .used_o(b_used)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  sv, fmt, br;
    logic [27:0] op;
    logic [19:0] rg;
    logic [63:0] opd;
    int          cnt;
    int          used;
  } exp_t;

  int checks = 0;
  int failures = 0;
  logic [BW-1:0] q[$];
  bit exp_ov = 1'b0;
  bit last_acc;
  bit seen_rdy;
  int dut_pops = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference parse straight from the instruction layout, indexing the bundle MSB-first.
  function automatic exp_t parse(input logic [BW-1:0] b, input int iw, input bit bstop);
    exp_t e;
    int off;
    int len;
    logic f;
    e = '0;
    off = 0;
    for (int k = 0; k < iw; k++) begin
      if (off >= BW) break;
      f = b[59-off];
      len = f ? 30 : 19;
      if (off + len > BW) break;
      e.sv[k]  = 1'b1;
      e.fmt[k] = f;
      e.br[k]  = b[58-off];
      for (int i = 0; i < 7; i++) e.op[7*k+i] = b[51-off+i];
      for (int i = 0; i < 5; i++) e.rg[5*k+i] = b[46-off+i];
      if (f) for (int i = 0; i < 16; i++) e.opd[16*k+i] = b[30-off+i];
      else   for (int i = 0; i < 5; i++)  e.opd[16*k+i] = b[41-off+i];
      e.cnt++;
      e.used += len;
      off += len;
      if (bstop && e.br[k]) break;
    end
    return e;
  endfunction

  task automatic cyc(input logic iv, input logic [BW-1:0] bv, input logic ordy,
                     input logic fl, input logic rs);
    int  s1_n;
    bit  exp_rdy, load;
    exp_t ea, eb;
    in_valid = iv; bundle = bv; out_ready = ordy; flush = fl; reset = rs;
    @(negedge clk);
    s1_n = q.size() - (exp_ov ? 1 : 0);
    exp_rdy = !rs && !fl && (s1_n == 0 || !exp_ov || ordy);
    seen_rdy = a_in_ready;
    chk("a_in_ready", a_in_ready, exp_rdy);
    chk("b_in_ready", b_in_ready, exp_rdy);
    chk("a_out_valid", a_ov, exp_ov);
    chk("b_out_valid", b_ov, exp_ov);
    if (a_ov && ordy) dut_pops++;
    if (exp_ov) begin
      ea = parse(q[0], 2, 1'b0);
      eb = parse(q[0], 3, 1'b1);
      chk("a_slot_valid", a_sv, ea.sv);   chk("b_slot_valid", b_sv, eb.sv);
      chk("a_format", a_fmt, ea.fmt);     chk("b_format", b_fmt, eb.fmt);
      chk("a_branch", a_br, ea.br);       chk("b_branch", b_br, eb.br);
      chk("a_opcode", a_op, ea.op);       chk("b_opcode", b_op, eb.op);
      chk("a_reg", a_rg, ea.rg);          chk("b_reg", b_rg, eb.rg);
      chk("a_operand", a_opd, ea.opd);    chk("b_operand", b_opd, eb.opd);
      chk("a_count", a_cnt, ea.cnt);      chk("b_count", b_cnt, eb.cnt);
      chk("a_used", a_used, ea.used);     chk("b_used", b_used, eb.used);
    end
    last_acc = 1'b0;
    if (rs || fl) begin
      q.delete();
      exp_ov = 1'b0;
    end else begin
      load = (s1_n > 0) && (!exp_ov || ordy);
      if (exp_ov && ordy) void'(q.pop_front());
      exp_ov = load ? 1'b1 : (exp_ov && !ordy);
      if (iv && exp_rdy) begin
        q.push_back(bv);
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input logic [BW-1:0] v);
    cyc(1'b1, v, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, {a_ov, a_sv, a_fmt, a_br, a_op, a_rg, a_opd, a_cnt, a_used}, '0);
    chk({tag, "_b"}, {b_ov, b_sv, b_fmt, b_br, b_op, b_rg, b_opd, b_cnt, b_used}, '0);
  endtask

  logic [BW-1:0] v;
  logic [BW-1:0] bp[4];
  int idx;
  int rdy_low;
  int pops0;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bundle = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_state");
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Two longs, branch on slot 1.
    v = {1'b1, 1'b0, 7'h12, 5'd3, 16'hBEEF, 1'b1, 1'b1, 7'h40, 5'd31, 16'h0001};
    directed(v);
    chk("t1_sv", a_sv, 2'b11);
    chk("t1_count", a_cnt, 2'd2);
    chk("t1_used", a_used, 6'd60);
    chk("t1_opd0", a_opd[15:0], 16'hBEEF);
    chk("t1_opd1", a_opd[31:16], 16'h0001);
    chk("t1_branch", a_br, 2'b10);
    chk("t1_b_sv", b_sv, 3'b011);

    // Short then long.
    v = {1'b0, 1'b0, 7'h05, 5'd1, 5'd9, 1'b1, 1'b0, 7'h33, 5'd7, 16'h1234, 11'h5A5};
    directed(v);
    chk("t2_count", a_cnt, 2'd2);
    chk("t2_used", a_used, 6'd49);
    chk("t2_opd0", a_opd[15:0], 16'h0009);
    chk("t2_format", a_fmt, 2'b10);

    // Long + short, 11 bits left for slot 2.
    v = {1'b1, 1'b0, 7'h21, 5'd2, 16'hCAFE, 1'b0, 1'b0, 7'h11, 5'd4, 5'd17, 11'h000};
    directed(v);
    chk("t3_sv", b_sv, 3'b011);
    chk("t3_count", b_cnt, 2'd2);
    chk("t3_used", b_used, 6'd49);
    chk("t3_slot2", {b_fmt[2], b_br[2], b_op[20:14], b_rg[14:10], b_opd[47:32]}, '0);

    // Three shorts, branch on slot 0.
    v = {1'b0, 1'b1, 7'h01, 5'd1, 5'd1, 1'b0, 1'b0, 7'h02, 5'd2, 5'd2,
         1'b0, 1'b0, 7'h03, 5'd3, 5'd3, 3'b000};
    directed(v);
    chk("t4_sv", b_sv, 3'b001);
    chk("t4_count", b_cnt, 2'd1);
    chk("t4_used", b_used, 6'd19);
    chk("t4_a_used", a_used, 6'd38);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Backpressure: four bundles, out_ready low for three cycles mid-stream.
    for (int i = 0; i < 4; i++) bp[i] = BW'({$urandom(), $urandom()});
    idx = 0;
    rdy_low = 0;
    pops0 = dut_pops;
    for (int c = 0; c < 14; c++) begin
      cyc(idx < 4, bp[idx & 3], !(c >= 3 && c <= 5), 1'b0, 1'b0);
      if (last_acc) idx++;
      if (!seen_rdy) rdy_low++;
    end
    chk("bp_ready_drop", rdy_low > 0, 1'b1);
    chk("bp_all_out", dut_pops - pops0, 4);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      cyc($urandom_range(0, 3) != 0, BW'({$urandom(), $urandom()}),
          $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, 1'b0);
    end

    // Flush with both stages full; flush also beats out_ready.
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, BW'({$urandom(), $urandom()}), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, BW'({$urandom(), $urandom()}), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, BW'({$urandom(), $urandom()}), 1'b1, 1'b1, 1'b0);
    chk("flush_ov", a_ov, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Reset (together with flush) with both stages full.
    cyc(1'b1, BW'({$urandom(), $urandom()}), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, BW'({$urandom(), $urandom()}), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, BW'({$urandom(), $urandom()}), 1'b1, 1'b1, 1'b1);
    chk_zero("reset_full");
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("post_reset_ready", a_in_ready, 1'b1);
    repeat (2) cyc(1'b1, BW'({$urandom(), $urandom()}), 1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
